// File: rtl/exe_hazard_ctrl_if.sv
// exe_hazard_ctrl_if: ID-side inputs and EXE-side control outputs of the
// EXE hazard / forwarding controller, bundled for a single module port.
//   freeze, branch_taken       : pipeline hold, branch flush of ID
//   id_*                       : decoded fields of the instruction in ID
//   alu_src1_sel/alu_src2_sel  : EXE operand selects (00 regfile, 01 MEM, 10 WB)
//   stall, stall_count         : load-use stall request and its saturating count
// Modports: master = pipeline side (drives ID fields), slave = controller.
interface exe_hazard_ctrl_if #(
  parameter int REG_ADDR_LEN  = 4,
  parameter int STALL_CNT_LEN = 16
);
  logic                     freeze;
  logic                     branch_taken;
  logic                     id_valid;
  logic [REG_ADDR_LEN-1:0]  id_src1;
  logic [REG_ADDR_LEN-1:0]  id_src2;
  logic                     id_src1_en;
  logic                     id_src2_en;
  logic [REG_ADDR_LEN-1:0]  id_dest;
  logic                     id_wb_en;
  logic                     id_mem_r_en;
  logic [1:0]               alu_src1_sel;
  logic [1:0]               alu_src2_sel;
  logic                     stall;
  logic [STALL_CNT_LEN-1:0] stall_count;

  modport master (
    output freeze, branch_taken, id_valid, id_src1, id_src2, id_src1_en,
           id_src2_en, id_dest, id_wb_en, id_mem_r_en,
    input  alu_src1_sel, alu_src2_sel, stall, stall_count
  );

  modport slave (
    input  freeze, branch_taken, id_valid, id_src1, id_src2, id_src1_en,
           id_src2_en, id_dest, id_wb_en, id_mem_r_en,
    output alu_src1_sel, alu_src2_sel, stall, stall_count
  );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: hazard and forwarding controller for the EXE stage.
// Keeps shadow tags for the EXE, MEM and WB stages, drives the EXE operand
// selects and requests a one-cycle IF/ID stall (with an EXE bubble) on a
// load-use hazard. All state holds while freeze is high.
// Ports:
//   clk : pipeline clock, rising edge
//   rst : synchronous active-low reset
//   hz  : exe_hazard_ctrl_if.slave (freeze, branch_taken, ID fields in;
//         alu_src1_sel, alu_src2_sel, stall, stall_count out)
// Build option: define EXE_FORWARDING_EN for MEM/WB forwarding with load-use
// stalls only; otherwise selects are 00 and any EXE/MEM producer stalls.
module exe_hazard_ctrl #(
  parameter int REG_ADDR_LEN  = 4,
  parameter int STALL_CNT_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  exe_hazard_ctrl_if.slave    hz
);

  // Only the slot fields that can influence an output in the selected build
  // are stored; the rest of the shadow pipeline would be dead state.
  logic                     ex_valid;
  logic                     ex_wb_en;
  logic [REG_ADDR_LEN-1:0]  ex_dest;
  logic                     mem_valid;
  logic                     mem_wb_en;
  logic [REG_ADDR_LEN-1:0]  mem_dest;
  logic [STALL_CNT_LEN-1:0] cnt;
  logic                     stall;
  logic                     bubble;

`ifdef EXE_FORWARDING_EN
  logic                     ex_mem_r_en;
  logic [REG_ADDR_LEN-1:0]  ex_src1;
  logic [REG_ADDR_LEN-1:0]  ex_src2;
  logic                     ex_src1_en;
  logic                     ex_src2_en;
  logic                     wb_valid;
  logic                     wb_wb_en;
  logic [REG_ADDR_LEN-1:0]  wb_dest;
  logic [1:0]               sel1;
  logic [1:0]               sel2;

  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    // WB first, then MEM, so a MEM hit overrides a WB hit.
    if (wb_valid && wb_wb_en && ex_src1_en && (wb_dest == ex_src1))   sel1 = 2'b10;
    if (mem_valid && mem_wb_en && ex_src1_en && (mem_dest == ex_src1)) sel1 = 2'b01;
    if (wb_valid && wb_wb_en && ex_src2_en && (wb_dest == ex_src2))   sel2 = 2'b10;
    if (mem_valid && mem_wb_en && ex_src2_en && (mem_dest == ex_src2)) sel2 = 2'b01;
  end

  always_comb begin
    stall = 1'b0;
    if (hz.id_valid && ex_valid && ex_mem_r_en && ex_wb_en &&
        ((hz.id_src1_en && (hz.id_src1 == ex_dest)) ||
         (hz.id_src2_en && (hz.id_src2 == ex_dest))))
      stall = 1'b1;
    if (hz.branch_taken)
      stall = 1'b0;
  end

  assign hz.alu_src1_sel = sel1;
  assign hz.alu_src2_sel = sel2;
`else
  always_comb begin
    stall = 1'b0;
    if (hz.id_valid) begin
      if (ex_valid && ex_wb_en &&
          ((hz.id_src1_en && (hz.id_src1 == ex_dest)) ||
           (hz.id_src2_en && (hz.id_src2 == ex_dest))))
        stall = 1'b1;
      if (mem_valid && mem_wb_en &&
          ((hz.id_src1_en && (hz.id_src1 == mem_dest)) ||
           (hz.id_src2_en && (hz.id_src2 == mem_dest))))
        stall = 1'b1;
    end
    if (hz.branch_taken)
      stall = 1'b0;
  end

  assign hz.alu_src1_sel = 2'b00;
  assign hz.alu_src2_sel = 2'b00;
`endif

  assign bubble = stall || hz.branch_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_wb_en  <= 1'b0;
      ex_dest   <= '0;
      mem_valid <= 1'b0;
      mem_wb_en <= 1'b0;
      mem_dest  <= '0;
      cnt       <= '0;
`ifdef EXE_FORWARDING_EN
      ex_mem_r_en <= 1'b0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_src1_en  <= 1'b0;
      ex_src2_en  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_wb_en    <= 1'b0;
      wb_dest     <= '0;
`endif
    end else if (!hz.freeze) begin
      mem_valid <= ex_valid;
      mem_wb_en <= ex_wb_en;
      mem_dest  <= ex_dest;
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_wb_en <= 1'b0;
        ex_dest  <= '0;
      end else begin
        ex_valid <= hz.id_valid;
        ex_wb_en <= hz.id_wb_en;
        ex_dest  <= hz.id_dest;
      end
      if (stall && (cnt != '1))
        cnt <= cnt + {{(STALL_CNT_LEN-1){1'b0}}, 1'b1};
`ifdef EXE_FORWARDING_EN
      wb_valid <= mem_valid;
      wb_wb_en <= mem_wb_en;
      wb_dest  <= mem_dest;
      if (bubble) begin
        ex_mem_r_en <= 1'b0;
        ex_src1     <= '0;
        ex_src2     <= '0;
        ex_src1_en  <= 1'b0;
        ex_src2_en  <= 1'b0;
      end else begin
        ex_mem_r_en <= hz.id_mem_r_en;
        ex_src1     <= hz.id_src1;
        ex_src2     <= hz.id_src2;
        ex_src1_en  <= hz.id_src1_en;
        ex_src2_en  <= hz.id_src2_en;
      end
`endif
    end
  end

  assign hz.stall       = stall;
  assign hz.stall_count = cnt;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb_exe_hazard_ctrl: bench for exe_hazard_ctrl. A small instruction-level
// model (three-entry pipeline of decoded instructions) predicts selects,
// stall and stall count each cycle. The counter is built narrow so that
// saturation is reached within the run.
module tb_exe_hazard_ctrl;
  localparam int RL = 4;
  localparam int CL = 4;

  typedef struct packed {
    logic          valid;
    logic          wb;
    logic          ld;
    logic          e1;
    logic          e2;
    logic [RL-1:0] dest;
    logic [RL-1:0] s1;
    logic [RL-1:0] s2;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_hazard_ctrl_if #(.REG_ADDR_LEN(RL), .STALL_CNT_LEN(CL)) hz ();

  exe_hazard_ctrl #(.REG_ADDR_LEN(RL), .STALL_CNT_LEN(CL)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // pipe[0] = EXE, pipe[1] = MEM, pipe[2] = WB
  ins_t        pipe [3];
  ins_t        cur;
  logic        br;
  logic        frz;
  int unsigned cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit consumes(input ins_t i, input logic [RL-1:0] r);
    return (i.e1 && i.s1 == r) || (i.e2 && i.s2 == r);
  endfunction

  function automatic bit exp_stall();
    if (br || !cur.valid) return 1'b0;
`ifdef EXE_FORWARDING_EN
    return pipe[0].valid && pipe[0].wb && pipe[0].ld && consumes(cur, pipe[0].dest);
`else
    for (int s = 0; s < 2; s++)
      if (pipe[s].valid && pipe[s].wb && consumes(cur, pipe[s].dest)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  // Returns the stage index supplying operand k: 1 = MEM, 2 = WB, 0 = regfile.
  function automatic int unsigned exp_sel(input int k);
`ifdef EXE_FORWARDING_EN
    logic          en;
    logic [RL-1:0] src;
    en  = (k == 1) ? pipe[0].e1 : pipe[0].e2;
    src = (k == 1) ? pipe[0].s1 : pipe[0].s2;
    for (int s = 1; s < 3; s++)
      if (pipe[s].valid && pipe[s].wb && en && src == pipe[s].dest) return s;
    return 0;
`else
    return (k == 0) ? 1 : 0;
`endif
  endfunction

  task automatic apply();
    hz.id_valid     = cur.valid;
    hz.id_wb_en     = cur.wb;
    hz.id_mem_r_en  = cur.ld;
    hz.id_src1_en   = cur.e1;
    hz.id_src2_en   = cur.e2;
    hz.id_dest      = cur.dest;
    hz.id_src1      = cur.s1;
    hz.id_src2      = cur.s2;
    hz.freeze       = frz;
    hz.branch_taken = br;
  endtask

  // Called at posedge+1; samples at the falling edge, then advances the model.
  task automatic step(output bit st);
    apply();
    #4;
    st = exp_stall();
    check_eq("sel1",  hz.alu_src1_sel, exp_sel(1));
    check_eq("sel2",  hz.alu_src2_sel, exp_sel(2));
    check_eq("stall", hz.stall, st);
    check_eq("count", hz.stall_count, cnt);
    if (!rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      cnt = 0;
    end else if (!frz) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (st || br) ? '0 : cur;
      if (st && cnt < (1 << CL) - 1) cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic [RL-1:0] dest, input logic wb, input logic ld,
                              input logic [RL-1:0] s1, input logic e1,
                              input logic [RL-1:0] s2, input logic e2);
    ins_t i;
    i = '0;
    i.valid = 1'b1; i.dest = dest; i.wb = wb; i.ld = ld;
    i.s1 = s1; i.e1 = e1; i.s2 = s2; i.e2 = e2;
    return i;
  endfunction

  // Holds the instruction in ID for as long as the model says it is stalled.
  task automatic issue(input ins_t i);
    bit st;
    cur = i;
    st  = 1'b1;
    for (int n = 0; n < 4 && st; n++) step(st);
  endtask

  task automatic idle(input int n);
    bit st;
    cur = '0;
    for (int k = 0; k < n; k++) step(st);
  endtask

  ins_t r;
  bit   st;

  initial begin
    rst = 1'b0;
    frz = 1'b0;
    br  = 1'b0;
    cur = ins_t'($urandom);
    apply();
    @(posedge clk); #1;
    cur = ins_t'($urandom);
    apply();
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    cnt = 0;
    rst = 1'b1;

    // Post-reset state with live ID inputs
    cur = mk(4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1);
    step(st);
    idle(2);

    // ALU chain: ADD R1,R2,R3 ; SUB R2,R1,R3 ; ORR R7,R1,R0
    issue(mk(4'd1, 1'b1, 1'b0, 4'd2, 1'b1, 4'd3, 1'b1));
    issue(mk(4'd2, 1'b1, 1'b0, 4'd1, 1'b1, 4'd3, 1'b1));
    issue(mk(4'd7, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b1));
    idle(3);

    // Load-use: LDR R4 ; ADD R5,R0,R4
    issue(mk(4'd4, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 1'b0));
    issue(mk(4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 4'd4, 1'b1));
    idle(3);

    // Double match on R6 from MEM and WB
    issue(mk(4'd6, 1'b1, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0));
    issue(mk(4'd6, 1'b1, 1'b0, 4'd1, 1'b0, 4'd2, 1'b0));
    issue(mk(4'd8, 1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1));
    idle(3);

    // Branch resolved while a load-use hazard is pending
    issue(mk(4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0));
    cur = mk(4'd5, 1'b1, 1'b0, 4'd4, 1'b1, 4'd4, 1'b1);
    br  = 1'b1;
    step(st);
    br  = 1'b0;
    idle(3);

    // Freeze held across a load-use stall
    issue(mk(4'd8, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0));
    cur = mk(4'd9, 1'b1, 1'b0, 4'd8, 1'b1, 4'd2, 1'b1);
    frz = 1'b1;
    for (int k = 0; k < 3; k++) step(st);
    frz = 1'b0;
    issue(cur);
    idle(3);

    // Reset in the middle of a stall
    issue(mk(4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0));
    cur = mk(4'd3, 1'b1, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0);
    rst = 1'b0;
    step(st);
    rst = 1'b1;
    step(st);
    idle(2);

    // Random traffic on a small tag range to provoke frequent hazards
    for (int c = 0; c < 800; c++) begin
      r       = ins_t'($urandom);
      r.dest  = RL'($urandom_range(0, 3));
      r.s1    = RL'($urandom_range(0, 3));
      r.s2    = RL'($urandom_range(0, 3));
      r.valid = ($urandom_range(0, 7) != 0);
      cur     = r;
      frz     = ($urandom_range(0, 7) == 0);
      br      = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 199) != 0);
      step(st);
    end
    rst = 1'b1;
    frz = 1'b0;
    br  = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
